// File: rtl/generate_subkeys.sv
// DES key schedule: PC-1, cumulative C/D rotations and PC-2 computed combinationally, one register stage; 1-cycle latency, new key every cycle, no backpressure.
// Defining GENERATE_SUBKEYS_PARITY_CHECK_EN adds a registered parity_err flag for keys that violate DES odd parity.
module generate_subkeys (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    output logic [47:0] sub_key1,
    output logic [47:0] sub_key2,
    output logic [47:0] sub_key3,
    output logic [47:0] sub_key4,
    output logic [47:0] sub_key5,
    output logic [47:0] sub_key6,
    output logic [47:0] sub_key7,
    output logic [47:0] sub_key8,
    output logic [47:0] sub_key9,
    output logic [47:0] sub_key10,
    output logic [47:0] sub_key11,
    output logic [47:0] sub_key12,
    output logic [47:0] sub_key13,
    output logic [47:0] sub_key14,
    output logic [47:0] sub_key15,
    output logic [47:0] sub_key16,
`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
    output logic        parity_err,
`endif
    output logic        sub_keys_vld
);

    // Tables use DES bit numbers (1 = MSB); bit b of an N-bit vector lives at index N-b.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Running sum of the per-round shifts, so every round rotates C0/D0 directly instead of chaining.
    localparam int ROT_CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    logic [27:0] c0;
    logic [27:0] d0;
    logic [47:0] ks   [16];
    logic [47:0] ks_q [16];
    logic        vld_q;

    always_comb begin : pc1_map
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1[i]];
        end
        c0 = cd[55:28];
        d0 = cd[27:0];
    end

    always_comb begin : schedule
        logic [55:0] c_dbl;
        logic [55:0] d_dbl;
        logic [55:0] cd_n;
        c_dbl = '0;
        d_dbl = '0;
        cd_n  = '0;
        ks    = '{default: '0};
        for (int n = 0; n < 16; n++) begin
            // Upper half of a doubled word shifted left is the left rotation; a shift of 28 returns C0/D0.
            c_dbl = {c0, c0} << ROT_CUM[n];
            d_dbl = {d0, d0} << ROT_CUM[n];
            cd_n  = {c_dbl[55:28], d_dbl[55:28]};
            for (int j = 0; j < 48; j++) begin
                ks[n][47-j] = cd_n[56-PC2[j]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_q  <= '{default: '0};
            vld_q <= 1'b0;
        end else begin
            ks_q  <= ks;
            vld_q <= 1'b1;
        end
    end

`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
    logic par_bad;
    logic par_q;

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[b*8 +: 8])) begin
                par_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_bad;
        end
    end

    assign parity_err = par_q;
`endif

    assign sub_keys_vld = vld_q;
    assign sub_key1     = ks_q[0];
    assign sub_key2     = ks_q[1];
    assign sub_key3     = ks_q[2];
    assign sub_key4     = ks_q[3];
    assign sub_key5     = ks_q[4];
    assign sub_key6     = ks_q[5];
    assign sub_key7     = ks_q[6];
    assign sub_key8     = ks_q[7];
    assign sub_key9     = ks_q[8];
    assign sub_key10    = ks_q[9];
    assign sub_key11    = ks_q[10];
    assign sub_key12    = ks_q[11];
    assign sub_key13    = ks_q[12];
    assign sub_key14    = ks_q[13];
    assign sub_key15    = ks_q[14];
    assign sub_key16    = ks_q[15];

endmodule

// File: tb/tb_generate_subkeys.sv
// Bench for generate_subkeys: known DES vectors, random back-to-back keys against a bit-level reference model, async reset.
module tb_generate_subkeys;

    logic        clk;
    logic        rst;
    logic [63:0] key;
    logic [47:0] sko [16];
    logic        sub_keys_vld;
`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int errors = 0;
    int checks = 0;

    generate_subkeys dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .sub_key1     (sko[0]),
        .sub_key2     (sko[1]),
        .sub_key3     (sko[2]),
        .sub_key4     (sko[3]),
        .sub_key5     (sko[4]),
        .sub_key6     (sko[5]),
        .sub_key7     (sko[6]),
        .sub_key8     (sko[7]),
        .sub_key9     (sko[8]),
        .sub_key10    (sko[9]),
        .sub_key11    (sko[10]),
        .sub_key12    (sko[11]),
        .sub_key13    (sko[12]),
        .sub_key14    (sko[13]),
        .sub_key15    (sko[14]),
        .sub_key16    (sko[15]),
`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
        .parity_err   (parity_err),
`endif
        .sub_keys_vld (sub_keys_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: works on arrays of DES-numbered bits, applying the per-round shift one position at a time.
    function automatic logic [767:0] ref_sched(input logic [63:0] k);
        int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                         63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
        int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                         41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
        int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
        bit kb [64];
        bit c [28];
        bit d [28];
        bit tc;
        bit td;
        logic [767:0] res;
        res = '0;
        for (int i = 0; i < 64; i++) kb[i] = k[63-i];
        for (int i = 0; i < 28; i++) begin
            c[i] = kb[pc1[i]-1];
            d[i] = kb[pc1[i+28]-1];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < shifts[r]; s++) begin
                tc = c[0];
                td = d[0];
                for (int j = 0; j < 27; j++) begin
                    c[j] = c[j+1];
                    d[j] = d[j+1];
                end
                c[27] = tc;
                d[27] = td;
            end
            for (int j = 0; j < 48; j++) begin
                res[r*48 + 47 - j] = (pc2[j] <= 28) ? c[pc2[j]-1] : d[pc2[j]-29];
            end
        end
        return res;
    endfunction

    function automatic logic ref_parity(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[b*8 +: 8]) % 2 == 0) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic check_sched(input string tag, input logic [63:0] k);
        logic [767:0] exp;
        exp = ref_sched(k);
        for (int n = 0; n < 16; n++) begin
            check($sformatf("%s_k%0d", tag, n + 1), {16'h0, sko[n]}, {16'h0, exp[n*48 +: 48]});
        end
        check({tag, "_vld"}, {63'h0, sub_keys_vld}, 64'h1);
`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
        check({tag, "_par"}, {63'h0, parity_err}, {63'h0, ref_parity(k)});
`endif
    endtask

    task automatic check_zero(input string tag);
        for (int n = 0; n < 16; n++) begin
            check($sformatf("%s_k%0d", tag, n + 1), {16'h0, sko[n]}, 64'h0);
        end
        check({tag, "_vld"}, {63'h0, sub_keys_vld}, 64'h0);
`ifdef GENERATE_SUBKEYS_PARITY_CHECK_EN
        check({tag, "_par"}, {63'h0, parity_err}, 64'h0);
`endif
    endtask

    task automatic apply(input logic [63:0] k);
        @(negedge clk);
        key = k;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    initial begin
        logic [63:0] rk;
        rst = 1'b1;
        key = KEY_A;
        #2;
        check_zero("reset_async");
        #5;
        check_zero("reset_held_edge");

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_sched("first_after_rst", KEY_A);
        check("known_k1",  {16'h0, sko[0]},  {16'h0, 48'h1B02EFFC7072});
        check("known_k2",  {16'h0, sko[1]},  {16'h0, 48'h79AED9DBC9E5});
        check("known_k16", {16'h0, sko[15]}, {16'h0, 48'hCB3D8B0E17F5});

        apply(64'h0);
        check_sched("zero_key", 64'h0);
        for (int n = 0; n < 16; n++) check($sformatf("zero_const_k%0d", n + 1), {16'h0, sko[n]}, 64'h0);

        apply(64'hFFFFFFFFFFFFFFFF);
        check_sched("ones_key", 64'hFFFFFFFFFFFFFFFF);
        for (int n = 0; n < 16; n++) check($sformatf("ones_const_k%0d", n + 1), {16'h0, sko[n]}, {16'h0, 48'hFFFFFFFFFFFF});

        apply(KEY_A ^ 64'h1);
        check_sched("par_flip", KEY_A ^ 64'h1);
        check("par_flip_k1",  {16'h0, sko[0]},  {16'h0, 48'h1B02EFFC7072});
        check("par_flip_k16", {16'h0, sko[15]}, {16'h0, 48'hCB3D8B0E17F5});

        // Fresh key every cycle: each edge must show the schedule of the key sampled at that edge.
        for (int i = 0; i < 40; i++) begin
            rk = {$urandom, $urandom};
            apply(rk);
            check_sched($sformatf("rand%0d", i), rk);
        end

        apply(KEY_A);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midstream_rst");
        @(negedge clk);
        rk = {$urandom, $urandom};
        key = rk;
        #1;
        check_zero("rst_still_high");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_sched("after_release", rk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
